// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between
// the execute path (req0) and the address/branch-compare helper (req1).
// One operation in flight; operands and results are registered so the ALU
// is never driven combinationally from requester inputs.
module alu_share_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RR_INIT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [3:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req1_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    output logic            rsp0_zero,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            rsp1_zero,
    output logic [XLEN-1:0] alu_operand_a,
    output logic [XLEN-1:0] alu_operand_b,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic RR_INIT_BIT = (RR_INIT != 0);

    logic [1:0]      state_q,   state_d;
    logic [XLEN-1:0] op_a_q,    op_a_d;
    logic [XLEN-1:0] op_b_q,    op_b_d;
    logic [3:0]      op_code_q, op_code_d;
    logic            owner_q,   owner_d;
    logic            rr_ptr_q,  rr_ptr_d;
    logic [XLEN-1:0] res_q,     res_d;
    logic            zf_q,      zf_d;

    logic            winner;
    logic            grant_any;
    logic            rsp_taken;

    // Pick the winner: a lone requester wins, contention goes to rr_ptr
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = rr_ptr_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
        grant_any  = rst_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
        req0_ready = grant_any && !winner;
        req1_ready = grant_any && winner;
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_code_d = op_code_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        res_d     = res_q;
        zf_d      = zf_q;
        rsp_taken = owner_q ? rsp1_ready : rsp0_ready;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    op_a_d    = winner ? req1_a  : req0_a;
                    op_b_d    = winner ? req1_b  : req0_b;
                    op_code_d = winner ? req1_op : req0_op;
                    owner_d   = winner;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = alu_result;
                zf_d    = alu_zero;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Pointer moves on completion only, so a grant never skews fairness
                if (rsp_taken) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            owner_q   <= 1'b0;
            rr_ptr_q  <= RR_INIT_BIT;
            res_q     <= '0;
            zf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_code_q <= op_code_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            res_q     <= res_d;
            zf_q      <= zf_d;
        end
    end

    // Response channels and registered ALU drive
    always_comb begin
        rsp0_valid    = rst_n && (state_q == ST_RESP) && !owner_q;
        rsp1_valid    = rst_n && (state_q == ST_RESP) &&  owner_q;
        rsp0_result   = res_q;
        rsp1_result   = res_q;
        rsp0_zero     = zf_q;
        rsp1_zero     = zf_q;
        alu_operand_a = op_a_q;
        alu_operand_b = op_b_q;
        alu_control   = op_code_q;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational RV32I ALU between two requesters: req0 = execute path, req1 = address/branch-compare helper.
- Each requester hands over operands and an op code with a valid/ready handshake.
- The arbiter grants round-robin, drives the ALU from registered operands, and returns the registered result and zero flag on a per-requester response channel.
- One operation is in flight at a time.

Parameters:
- XLEN, 32, operand/result width.
- RR_INIT, 0, requester favoured first after reset (0 or 1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  request valid
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a / req1_a  in  XLEN  operand A
- req0_b / req1_b  in  XLEN  operand B
- req0_op / req1_op  in  4  ALU op code (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9)
- rsp0_valid / rsp1_valid  out  1  response valid
- rsp0_ready / rsp1_ready  in  1  requester takes response
- rsp0_result / rsp1_result  out  XLEN  captured ALU result
- rsp0_zero / rsp1_zero  out  1  captured zero flag
- alu_operand_a  out  XLEN  to ALU
- alu_operand_b  out  XLEN  to ALU
- alu_control  out  4  to ALU
- alu_result  in  XLEN  from ALU
- alu_zero  in  1  from ALU

Behaviour:
- FSM states: IDLE, EXEC, RESP. Registers: op_a, op_b, op_code, owner (1 bit), rr_ptr (1 bit), res, zf.
- Reset (rst_n low at a clk edge):
  - state=IDLE, rr_ptr=RR_INIT, op_a/op_b/res=0, op_code=0 (ADD), zf=0, owner=0.
  - req*_ready=0 and rsp*_valid=0 while rst_n is low.
  - Reset mid-operation drops the in-flight op silently; no response is ever issued for it.
- IDLE, grant selection:
  - Only one requester valid: that requester wins.
  - Both valid: rr_ptr wins.
  - reqN_ready=1 combinationally for the winner only; 0 otherwise. Ready never asserts outside IDLE.
- IDLE, on handshake: capture a/b/op into op_a/op_b/op_code, owner=winner, go to EXEC.
- No valid requests: stay in IDLE.
- EXEC (exactly 1 cycle): alu_* outputs show the captured op. At the clock edge, res<=alu_result, zf<=alu_zero, go to RESP.
- RESP:
  - rsp[owner]_valid=1, rsp[owner]_result=res, rsp[owner]_zero=zf. The other response channel has valid=0.
  - On rsp[owner]_ready=1: rr_ptr<=~owner, go to IDLE.
  - Otherwise hold; res and zf stay stable.
- alu_operand_a/b and alu_control are driven from op_a/op_b/op_code in every state (registered, glitch-free). No combinational path from req* inputs to alu_*.
- Latency: handshake in cycle N gives rsp_valid in cycle N+2. Peak throughput is one op per 3 cycles.
- Requester valid may drop before it is granted; there is no penalty.
- A request arriving from one requester while the other is in EXEC/RESP waits in IDLE arbitration.
- A request and a response on the same requester in the same cycle cannot happen, because ready is 0 in RESP.
- rr_ptr updates only on response completion, not on grant.
- Undefined op codes (10-15) are forwarded unchanged. The response carries whatever the ALU returns.
- Width rules: results are the full XLEN with no truncation. Shift amount comes from op_b[4:0] inside the ALU; the arbiter does not alter operands.

Test Plan:
- Single op: req0 ADD a=0x00000005, b=0x00000003 -> req0_ready in cycle N, rsp0_valid in N+2 with result=0x00000008, zero=0; rsp1_valid stays 0.
- Contention: both valid from reset, RR_INIT=0; req0 SUB 7-7, req1 SLT a=0xFFFFFFFF, b=1 -> req0 served first (result 0, zero=1), then req1 (result 1, zero=0); every response is held for at least one cycle.
- Fairness: both requesters hold valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; no requester is starved.
- Backpressure: rsp1_ready held 0 for 5 cycles after SRA a=0x80000000, b=4 -> rsp1_result stays 0xF8000000; req0_ready stays 0 throughout; IDLE resumes one cycle after rsp1_ready=1.
- Reset mid-op: rst_n low during EXEC -> next cycle state=IDLE, all rsp_valid=0, alu_control=0, rr_ptr=RR_INIT; a fresh request is then served normally.
- Undefined op 4'hC on req1 -> alu_control=4'hC in EXEC; rsp1_result equals the ALU output (0), zero=1.
